sdram_frame_reader: RTL and testbench
=====================================

# sdram_frame_reader

Avalon-MM pipelined read master that fetches a rendered Julia-set frame back out of SDRAM, starting at the frame base address where the pixel writer deposits it. It issues word reads, tracks outstanding transactions against free buffer space, and presents the returned words on a valid/ready pixel stream for the display or readback path. It pairs with the CSR/writer block: the writer fills the frame, this block drains it.

## Interface
Parameters:
- ADDRESSWIDTH, 32, master address width (byte addresses)
- DATAWIDTH, 32, read data / pixel word width
- BASE_ADDR, 32'h08000000, SDRAM byte address of frame word 0
- NUM_WORDS, 307200, frame length in words (min 1)
- FIFO_DEPTH, 8, pixel buffer depth (power of 2, ≥2)

Ports:
- clk  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to read one frame; ignored while busy
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when last word leaves the stream
- master_address  out  ADDRESSWIDTH  read byte address
- master_read  out  1  read request
- master_readdata  in  DATAWIDTH  returned word
- master_readdatavalid  in  1  master_readdata valid this cycle
- master_waitrequest  in  1  slave stall; request not accepted while high
- pix_data  out  DATAWIDTH  stream word (FIFO head)
- pix_valid  out  1  pix_data valid
- pix_ready  in  1  consumer accepts when pix_valid && pix_ready

## Operation
- States: IDLE, FETCH, DRAIN. IDLE -start-> FETCH (issued=0, master_address=BASE_ADDR). FETCH -last read accepted-> DRAIN. DRAIN -last word popped-> IDLE with done=1.
- accept = master_read && !master_waitrequest. On accept: master_address += DATAWIDTH/8, issued += 1.
- Credit: pending = accepted reads not yet returned. master_read asserted in FETCH only when fifo_count + pending < FIFO_DEPTH; never overflows FIFO regardless of pix_ready.
- pending_next = pending + accept − (readdatavalid && pending>0); simultaneous accept and return leave pending unchanged.
- readdatavalid with pending==0 (stale response after reset) is dropped, not written.
- Returned words pushed to FIFO in arrival order; push and pop in same cycle allowed, count unchanged, including when full (pop frees the slot).
- Words counted on pop; done asserted in the cycle after the NUM_WORDS-th pop.
- Address arithmetic modulo 2^ADDRESSWIDTH; no wrap handling beyond that.

## Timing
- Reset values: busy=0, done=0, master_read=0, master_address=BASE_ADDR, pix_valid=0, pix_data=0; FIFO empty, counters 0, state IDLE.
- Reset mid-frame: all state cleared immediately; no further reads issued until next start.
- master_read and master_address registered; held stable while master_waitrequest high.
- start in cycle N -> master_read high in cycle N+1 (busy high in N+1).
- readdatavalid in cycle N -> pix_valid high in cycle N+1 if FIFO was empty (registered FIFO, show-ahead).
- pix_data stable while pix_valid && !pix_ready.
- Sustained throughput 1 word/cycle when waitrequest low, pix_ready high and read latency < FIFO_DEPTH.

## Structure
- Package sdram_frame_reader_pkg: state enum (IDLE, FETCH, DRAIN), default BASE_ADDR 32'h08000000, WORD_BYTES constant.
- Sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count, async active-low reset, show-ahead head register).
- Top holds FSM, address/issued/pending/popped counters, credit logic.

## Test plan
- NUM_WORDS=4, zero waitrequest, fixed read latency 3, pix_ready=1 -> addresses 0x08000000,04,08,0C once each; pix_data equals memory model words in order; done one cycle after 4th pop; busy low after.
- waitrequest high 5 cycles on 2nd read -> master_address held at 0x08000004 and master_read held for all 5 cycles; one accept only.
- pix_ready=0 throughout, FIFO_DEPTH=8, NUM_WORDS=20 -> exactly 8 reads accepted, then master_read low; releasing pix_ready completes all 20 words in order.
- NUM_WORDS=1 -> single read, single pixel, done pulse; start asserted while busy ignored (no second frame).
- Assert reset_n low with 3 reads pending, release, inject 3 stale readdatavalid -> pix_valid stays 0, FIFO empty; next start reads from 0x08000000.
- Random waitrequest/latency/pix_ready, NUM_WORDS=1000 -> scoreboard match, FIFO never overflows, pending never negative.

Source files
------------

// File: rtl/sdram_frame_reader_pkg.sv
// sdram_frame_reader_pkg: shared state encoding, default frame base and word sizing
package sdram_frame_reader_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2} state_e;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0800_0000;
  function automatic int word_bytes(input int dw);
    return dw / 8;
  endfunction
  localparam int WORD_BYTES = word_bytes(32);
endpackage

// File: rtl/sdram_frame_reader_sync_fifo.sv
// sync_fifo: show-ahead FIFO with registered head word
// Ports: clk/rst_n (async active-low); push_i/din_i write; pop_i consumes dout_o; full_o/empty_o/count_o status
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic do_push, do_pop;
  always_comb begin
    do_pop  = pop_i && count_q != '0;
    do_push = push_i && (count_q != CW'(DEPTH) || do_pop);
    rd_d    = rd_q + AW'(do_pop);
    wr_d    = wr_q + AW'(do_push);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
    // the new head may be the word being written this very cycle
    head_d  = count_d == '0 ? head_q : (do_push && rd_d == wr_q) ? din_i : mem[rd_d];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      head_q  <= head_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= din_i;
  end
  assign dout_o  = head_q;
  assign full_o  = count_q == CW'(DEPTH);
  assign empty_o = count_q == '0;
  assign count_o = count_q;
endmodule

// File: rtl/sdram_frame_reader.sv
// sdram_frame_reader: Avalon-MM pipelined read master streaming one frame out of SDRAM
// Ports: clk/reset_n (async active-low); start -> busy/done; master_* Avalon-MM read; pix_* valid/ready stream
module sdram_frame_reader
  import sdram_frame_reader_pkg::*;
#(
  parameter int ADDRESSWIDTH = 32,
  parameter int DATAWIDTH = 32,
  parameter logic [ADDRESSWIDTH-1:0] BASE_ADDR = ADDRESSWIDTH'(DEFAULT_BASE_ADDR),
  parameter int NUM_WORDS = 307200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [ADDRESSWIDTH-1:0] master_address,
  output logic                    master_read,
  input  logic [DATAWIDTH-1:0]    master_readdata,
  input  logic                    master_readdatavalid,
  input  logic                    master_waitrequest,
  output logic [DATAWIDTH-1:0]    pix_data,
  output logic                    pix_valid,
  input  logic                    pix_ready
);
  localparam int CW = $clog2(NUM_WORDS+1);
  localparam int PW = $clog2(FIFO_DEPTH+1);
  localparam logic [CW-1:0] LAST = CW'(NUM_WORDS);
  localparam logic [PW:0] DEPTH_L = (PW+1)'(FIFO_DEPTH);
  localparam logic [ADDRESSWIDTH-1:0] STEP = ADDRESSWIDTH'(word_bytes(DATAWIDTH));
  state_e state_q, state_d;
  logic [ADDRESSWIDTH-1:0] addr_q, addr_d;
  logic read_q, read_d, busy_q, done_q, done_d;
  logic [CW-1:0] issued_q, issued_d, popped_q, popped_d;
  logic [PW-1:0] pending_q, pending_d, fifo_count, cnt_next;
  logic [PW:0] used;
  logic fifo_full, fifo_empty, accept, ret, push, pop, start_go, last_pop;
  always_comb begin
    accept    = read_q && !master_waitrequest;
    // responses with nothing outstanding are leftovers from before a reset
    ret       = master_readdatavalid && pending_q != '0;
    pop       = pix_valid && pix_ready;
    push      = ret && (!fifo_full || pop);
    start_go  = state_q == IDLE && start;
    issued_d  = start_go ? '0 : issued_q + CW'(accept);
    popped_d  = start_go ? '0 : popped_q + CW'(pop);
    pending_d = pending_q + PW'(accept) - PW'(ret);
    cnt_next  = fifo_count + PW'(push) - PW'(pop);
    last_pop  = state_q == DRAIN && pop && popped_d == LAST;
    state_d   = start_go ? FETCH :
                (state_q == FETCH && accept && issued_d == LAST) ? DRAIN :
                last_pop ? IDLE : state_q;
    // every word in flight already owns a FIFO slot, so the buffer cannot overflow
    used      = {1'b0, cnt_next} + {1'b0, pending_d};
    read_d    = (read_q && master_waitrequest) ||
                (state_d == FETCH && issued_d != LAST && used < DEPTH_L);
    addr_d    = start_go ? BASE_ADDR : accept ? addr_q + STEP : addr_q;
    done_d    = last_pop;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      addr_q    <= BASE_ADDR;
      read_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      issued_q  <= '0;
      popped_q  <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      read_q    <= read_d;
      busy_q    <= state_d != IDLE;
      done_q    <= done_d;
      issued_q  <= issued_d;
      popped_q  <= popped_d;
      pending_q <= pending_d;
    end
  end
  sync_fifo #(.WIDTH(DATAWIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (push),
    .din_i   (master_readdata),
    .pop_i   (pop),
    .dout_o  (pix_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );
  assign pix_valid      = !fifo_empty;
  assign busy           = busy_q;
  assign done           = done_q;
  assign master_read    = read_q;
  assign master_address = addr_q;
endmodule

// File: tb/tb_sdram_frame_reader.sv
// tb_sdram_frame_reader: scoreboard bench for the SDRAM frame reader
module tb_sdram_frame_reader;
  localparam logic [31:0] BASE = 32'h0800_0000;
  localparam int NW = 20;
  localparam int DEP = 8;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  logic start = 1'b0, busy, done, mread, rdv = 1'b0, wreq = 1'b0, pix_valid, pix_ready = 1'b0;
  logic [31:0] maddr, rdata = '0, pix_data;
  logic start_b = 1'b0, busy_b, done_b, mread_b, rdv_b = 1'b0, pvalid_b;
  logic wreq_b = 1'b0, pready_b = 1'b1;
  logic [31:0] maddr_b, rdata_b = '0, pdata_b;
  sdram_frame_reader #(.NUM_WORDS(NW), .FIFO_DEPTH(DEP)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .master_address(maddr), .master_read(mread), .master_readdata(rdata),
    .master_readdatavalid(rdv), .master_waitrequest(wreq),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready)
  );
  sdram_frame_reader #(.NUM_WORDS(1), .FIFO_DEPTH(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .busy(busy_b), .done(done_b),
    .master_address(maddr_b), .master_read(mread_b), .master_readdata(rdata_b),
    .master_readdatavalid(rdv_b), .master_waitrequest(wreq_b),
    .pix_data(pdata_b), .pix_valid(pvalid_b), .pix_ready(pready_b)
  );
  int tests = 0, fails = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  // slave model for dut: in-order responses, per-read latency, scripted or random stalls
  int lat_min = 3, lat_max = 3, ready_mode = 0, stall_left = 0, stale_left = 0;
  bit rand_wr = 0;
  logic [31:0] stall_addr = '0;
  int stall_cnt = 0, stall_first = 0, stall_last = 0, accepts = 0, last_due = 0;
  logic [31:0] addr_log[$], radr_q[$];
  int due_q[$];
  initial begin
    int d;
    forever begin
      @(posedge clk);
      #1;
      pix_ready = ready_mode == 2 ? 1'($urandom_range(0, 1)) : ready_mode == 1;
      if (!reset_n) begin
        due_q.delete();
        radr_q.delete();
        rdv = 1'b0;
        wreq = 1'b0;
      end else begin
        if (mread && maddr == stall_addr && stall_left > 0) begin
          wreq = 1'b1;
          stall_left--;
          if (stall_cnt == 0) stall_first = cyc;
          stall_last = cyc;
          stall_cnt++;
        end else wreq = rand_wr ? ($urandom_range(0, 3) == 0) : 1'b0;
        if (mread && !wreq) begin
          addr_log.push_back(maddr);
          accepts++;
          d = cyc + 1 + int'($urandom_range(lat_min, lat_max));
          if (d <= last_due) d = last_due + 1;
          last_due = d;
          due_q.push_back(d);
          radr_q.push_back(maddr);
        end
        if (stale_left > 0) begin
          rdv = 1'b1;
          rdata = 32'hDEAD_0000 + stale_left;
          stale_left--;
        end else if (due_q.size() > 0 && due_q[0] <= cyc + 1) begin
          rdv = 1'b1;
          rdata = mem_word(radr_q.pop_front());
          void'(due_q.pop_front());
        end else begin
          rdv = 1'b0;
          rdata = '0;
        end
      end
    end
  end
  // slave model for dut_b: one-cycle latency, never stalls
  int b_accepts = 0, b_pix = 0, b_done = 0;
  logic b_prev = 1'b0;
  logic [31:0] b_prev_addr = '0;
  logic [31:0] exp_b[$];
  initial forever begin
    @(posedge clk);
    #1;
    rdv_b = reset_n && b_prev;
    rdata_b = mem_word(b_prev_addr);
    b_prev = reset_n && mread_b;
    b_prev_addr = maddr_b;
    if (reset_n && mread_b) b_accepts++;
  end
  // monitors: pop expected words on every stream handshake
  logic [31:0] exp_q[$];
  int pops = 0, total_pops = 0, last_pop_cyc = -100, done_cnt = 0, max_out = 0;
  logic prev_v = 1'b0, prev_r = 1'b0;
  logic [31:0] prev_d = '0;
  always @(negedge clk) begin
    if (reset_n) begin
      if (prev_v && !prev_r) check("pix_hold", pix_data, prev_d);
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL pix_extra: got 0x%0h expected no word", pix_data);
        end else check("pix_data", pix_data, exp_q.pop_front());
        total_pops++;
        pops++;
        if (pops == NW) begin
          last_pop_cyc = cyc;
          pops = 0;
        end
      end
      if (done) begin
        done_cnt++;
        check("done_timing", cyc, last_pop_cyc + 1);
      end
      if (accepts - total_pops > max_out) max_out = accepts - total_pops;
      if (pvalid_b && pready_b) begin
        b_pix++;
        if (exp_b.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL b_pix_extra: got 0x%0h expected no word", pdata_b);
        end else check("b_pix_data", pdata_b, exp_b.pop_front());
      end
      if (done_b) b_done++;
    end
    prev_v = reset_n && pix_valid;
    prev_r = pix_ready;
    prev_d = pix_data;
  end
  task automatic start_frame();
    for (int i = 0; i < NW; i++) exp_q.push_back(mem_word(BASE + 32'(4 * i)));
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic wait_done(input string name, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 5000);
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL %s: got no done after %0d cycles expected done", name, n);
    end
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, a0, d0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_read", mread, 0);
    check("rst_addr", maddr, BASE);
    check("rst_valid", pix_valid, 0);
    check("rst_data", pix_data, 0);
    check("rst_b_read", mread_b, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    ready_mode = 1;
    repeat (2) @(posedge clk);
    // nominal frame, latency 3, no stalls
    addr_log.delete();
    start_frame();
    check("start_read", mread, 1);
    check("start_busy", busy, 1);
    check("start_addr", maddr, BASE);
    wait_done("frame1", n);
    check("throughput", n <= 26, 1);
    check("busy_after", busy, 0);
    check("addr_count", addr_log.size(), NW);
    for (int i = 0; i < NW; i++)
      check("addr_seq", addr_log.size() > i ? addr_log[i] : 32'hFFFF_FFFF, BASE + 32'(4 * i));
    check("exp_empty1", exp_q.size(), 0);
    // five-cycle stall on the second read
    addr_log.delete();
    stall_addr = BASE + 32'd4;
    stall_left = 5;
    start_frame();
    wait_done("frame_stall", n);
    check("stall_cycles", stall_cnt, 5);
    check("stall_contig", stall_last - stall_first, 4);
    check("stall_count", addr_log.size(), NW);
    check("stall_addr1", addr_log.size() > 2 ? addr_log[1] : 32'hFFFF_FFFF, BASE + 32'd4);
    check("stall_addr2", addr_log.size() > 2 ? addr_log[2] : 32'hFFFF_FFFF, BASE + 32'd8);
    // backpressure: credit limits to FIFO depth
    ready_mode = 0;
    a0 = accepts;
    start_frame();
    repeat (40) @(negedge clk);
    check("credit_accepts", accepts - a0, DEP);
    check("credit_read_low", mread, 0);
    check("credit_valid", pix_valid, 1);
    ready_mode = 1;
    wait_done("frame_bp", n);
    check("exp_empty_bp", exp_q.size(), 0);
    // reset with reads outstanding, then stale responses
    lat_min = 10;
    lat_max = 10;
    a0 = accepts;
    start_frame();
    n = 0;
    while (accepts - a0 < 4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("pend_reached", accepts - a0 >= 4, 1);
    reset_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_read", mread, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    exp_q.delete();
    pops = 0;
    total_pops = accepts;
    stale_left = 3;
    lat_min = 3;
    lat_max = 3;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("stale_valid", pix_valid, 0);
      check("stale_read", mread, 0);
    end
    addr_log.delete();
    ready_mode = 1;
    start_frame();
    wait_done("frame_after_rst", n);
    check("rst_restart_addr", addr_log.size() > 0 ? addr_log[0] : 32'hFFFF_FFFF, BASE);
    check("exp_empty_rst", exp_q.size(), 0);
    // randomized stalls, latency and backpressure across several frames
    rand_wr = 1;
    lat_min = 1;
    lat_max = 6;
    ready_mode = 2;
    d0 = done_cnt;
    for (int f = 0; f < 10; f++) begin
      start_frame();
      wait_done("frame_rand", n);
    end
    check("rand_done_cnt", done_cnt - d0, 10);
    check("rand_exp_empty", exp_q.size(), 0);
    check("no_overflow", max_out <= DEP, 1);
    rand_wr = 0;
    ready_mode = 1;
    // single-word frame, second start while busy is ignored
    repeat (3) @(posedge clk);
    #1 start_b = 1'b1;
    exp_b.push_back(mem_word(BASE));
    @(posedge clk);
    #1 start_b = 1'b0;
    check("b_busy", busy_b, 1);
    @(posedge clk);
    #1 start_b = 1'b1;
    @(posedge clk);
    #1 start_b = 1'b0;
    repeat (20) @(negedge clk);
    check("b_accepts", b_accepts, 1);
    check("b_pixels", b_pix, 1);
    check("b_done", b_done, 1);
    check("b_busy_end", busy_b, 0);
    check("b_exp_empty", exp_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
